// File: rtl/cw_pkg.sv
// cw_pkg: control-word field positions, Psel encodings and sequencer states.
package cw_pkg;
  localparam int CW_W    = 31;
  localparam int PSEL_HI = 30;
  localparam int PSEL_LO = 29;
  localparam int REGW    = 8;
  localparam int RAMW    = 7;
  localparam int EN_MEM  = 6;
  localparam int EN_ALU  = 5;
  localparam int EN_B    = 4;
  localparam int EN_PC   = 3;
  localparam int BSEL    = 2;
  localparam int PCSEL   = 1;
  localparam int SL      = 0;
  localparam logic [CW_W-1:0] STROBE_MASK = 31'h0000_01F8;
  typedef enum logic [1:0] {PSEL_HOLD = 2'b00, PSEL_INC = 2'b01, PSEL_REL = 2'b10, PSEL_ABS = 2'b11} psel_t;
  typedef enum logic [1:0] {S_FETCH = 2'b00, S_CAP = 2'b01, S_EXE = 2'b10} fsm_t;
endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter with Psel/PCsel update mux.
module pc_unit
  import cw_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  psel_t       i_psel,
  input  logic        i_pcsel,
  input  logic [63:0] i_a_bus,
  input  logic [63:0] i_k,
  output logic [63:0] o_pc
);
  logic [63:0] w_op, w_next;
  always_comb begin
    w_op   = i_pcsel ? i_a_bus : i_k;
    w_next = i_psel == PSEL_INC ? o_pc + PC_STEP :
             i_psel == PSEL_REL ? o_pc + w_op :
             i_psel == PSEL_ABS ? w_op : o_pc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) o_pc <= RESET_PC;
    else if (i_en) o_pc <= w_next;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetches instructions, registers decoder control words and
// sequences micro-states, gating datapath strobes outside the execute phase.
module control_sequencer
  import cw_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [1:0]  state,
  input  logic [30:0] cw_in,
  input  logic [1:0]  next_state_in,
  input  logic [63:0] k_in,
  input  logic [63:0] a_bus,
  input  logic        dp_stall,
  output logic [63:0] pc,
  output logic [30:0] cw_out,
  output logic [63:0] k_out,
  output logic        executing
);
  fsm_t        r_fsm, w_nxt;
  logic        r_started;
  logic [31:0] r_ir;
  logic [1:0]  r_state, r_ns;
  logic [30:0] r_cw;
  logic [63:0] r_k;
  logic        w_take, w_step, w_exec;
  always_comb begin
    w_take = r_fsm == S_FETCH && r_started && imem_ack;
    w_step = r_fsm != S_FETCH && !dp_stall;
    w_exec = r_fsm == S_EXE && !dp_stall;
    w_nxt  = w_take ? S_CAP : !w_step ? r_fsm :
             r_fsm == S_CAP ? S_EXE : r_ns != 2'd0 ? S_CAP : S_FETCH;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) r_fsm <= S_FETCH;
    else r_fsm <= w_nxt;
  // cw/K/nextState recapture on every advancing edge; the capture cycle's edge lands the decode of the current instruction/state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_started <= 1'b0;
      r_ir      <= '0;
      r_state   <= '0;
      r_ns      <= '0;
      r_cw      <= '0;
      r_k       <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_take) begin
        r_ir    <= imem_data;
        r_state <= 2'd0;
      end
      if (w_exec) r_state <= r_ns;
      if (w_take || w_step) begin
        r_cw <= cw_in;
        r_k  <= k_in;
        r_ns <= next_state_in;
      end
    end
  pc_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk    (clock),
    .rst    (reset),
    .i_en   (w_exec),
    .i_psel (psel_t'(r_cw[PSEL_HI:PSEL_LO])),
    .i_pcsel(r_cw[PCSEL]),
    .i_a_bus(a_bus),
    .i_k    (r_k),
    .o_pc   (pc)
  );
  always_comb begin
    imem_req    = r_fsm == S_FETCH && r_started;
    imem_addr   = pc;
    instruction = r_ir;
    state       = r_state;
    cw_out      = r_fsm == S_EXE ? r_cw : r_cw & ~STROBE_MASK;
    k_out       = r_k;
    executing   = r_fsm != S_FETCH;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench; the bench plays instruction
// memory and a hash-based decoder, and predicts each execute step from the PC rules.
module tb_control_sequencer;
  localparam logic [63:0] RPC = 64'h100;
  logic        clock = 1'b0, reset = 1'b1;
  logic        imem_req, imem_ack = 1'b0, dp_stall = 1'b0, executing;
  logic [63:0] imem_addr, k_in, a_bus, pc, k_out;
  logic [31:0] imem_data = '0, instruction;
  logic [1:0]  state, next_state_in;
  logic [30:0] cw_in, cw_out;
  int          n_cmp = 0, n_bad = 0;
  bit          mon_on = 0, ovr = 0, run_stall = 0;
  typedef struct {logic [1:0] s; logic [30:0] cw; logic [63:0] k; logic [63:0] pc;} exp_t;
  exp_t q[$];

  control_sequencer #(.RESET_PC(RPC), .PC_STEP(64'd4)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instruction(instruction), .state(state),
    .cw_in(cw_in), .next_state_in(next_state_in), .k_in(k_in), .a_bus(a_bus),
    .dp_stall(dp_stall), .pc(pc), .cw_out(cw_out), .k_out(k_out), .executing(executing)
  );
  always #5 clock = ~clock;

  function automatic logic [31:0] hsh(input logic [31:0] i, input logic [1:0] s);
    return i ^ ({30'd0, s} * 32'h9E37_79B9);
  endfunction
  function automatic logic [30:0] dcw(input logic [31:0] i, input logic [1:0] s);
    logic [31:0] h = hsh(i, s);
    return h[30:0] | 31'h8;
  endfunction
  function automatic logic [63:0] dk(input logic [31:0] i, input logic [1:0] s);
    logic [31:0] h = hsh(i, s);
    return {h, ~h};
  endfunction
  function automatic logic [63:0] da(input logic [31:0] i, input logic [1:0] s);
    logic [31:0] h = hsh(i, s);
    return {~h, h} ^ 64'h0123_4567_89AB_CDEF;
  endfunction
  function automatic logic [1:0] dns(input logic [31:0] i, input logic [1:0] s);
    return s < i[1:0] ? s + 2'd1 : 2'd0;
  endfunction

  // Decoder stand-in: combinational in instruction/state, with a fixed override word for the reset test
  always_comb begin
    cw_in         = ovr ? 31'h6000_0088 : dcw(instruction, state);
    k_in          = ovr ? 64'hFFFF : dk(instruction, state);
    next_state_in = ovr ? 2'd0 : dns(instruction, state);
    a_bus         = da(instruction, state);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  initial forever begin
    @(negedge clock);
    dp_stall = run_stall && ($urandom_range(0, 2) == 0);
  end

  // Monitor: pops one expectation per non-stalled execute cycle and checks stall holds
  initial begin
    bit          pst = 0;
    logic [63:0] ppc;
    logic [1:0]  pstate;
    exp_t        e;
    forever begin
      @(negedge clock);
      #2;
      if (mon_on) begin
        if (!(executing && cw_out[3])) begin
          chk("idle_strobes", {62'd0, cw_out[8:7]}, 64'd0);
          pst = 0;
        end else begin
          if (pst) begin
            chk("stall_pc", pc, ppc);
            chk("stall_state", {62'd0, state}, {62'd0, pstate});
          end
          if (!dp_stall) begin
            if (q.size() == 0) fail("unexpected_execute");
            else begin
              e = q.pop_front();
              chk("state", {62'd0, state}, {62'd0, e.s});
              chk("cw_out", {33'd0, cw_out}, {33'd0, e.cw});
              chk("k_out", k_out, e.k);
              chk("pc", pc, e.pc);
            end
          end
          pst = dp_stall;
          ppc = pc;
          pstate = state;
        end
      end
    end
  end

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (imem_req) begin
        ok = 1;
        break;
      end
      imem_ack  = executing && ($urandom_range(0, 3) == 0);
      imem_data = $urandom;
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] mpc = RPC, op;
    logic [31:0] ins;
    logic [30:0] cw;
    logic [1:0]  s;
    bit          ok;
    #12;
    chk("rst_pc", pc, RPC);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_cw", {33'd0, cw_out}, 64'd0);
    chk("rst_k", k_out, 64'd0);
    chk("rst_ir", {32'd0, instruction}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_exec", {63'd0, executing}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("req_first_cycle", {63'd0, imem_req}, 64'd0);
    @(posedge clock);
    #1 chk("req_after", {63'd0, imem_req}, 64'd1);
    chk("addr_after", imem_addr, RPC);
    mon_on = 1;
    run_stall = 1;
    for (int n = 0; n < 40; n++) begin
      wait_req(ok);
      if (!ok) begin
        fail("fetch_wait");
        break;
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      chk("imem_addr", imem_addr, mpc);
      ins = $urandom;
      s = 2'd0;
      do begin
        cw = dcw(ins, s);
        q.push_back('{s: s, cw: cw, k: dk(ins, s), pc: mpc});
        op = cw[1] ? da(ins, s) : dk(ins, s);
        case (cw[30:29])
          2'b01: mpc = mpc + 64'd4;
          2'b10: mpc = mpc + op;
          2'b11: mpc = op;
          default: ;
        endcase
        s = dns(ins, s);
      end while (s != 2'd0);
      imem_ack = 1'b1;
      imem_data = ins;
      @(negedge clock);
      imem_ack = 1'b0;
      imem_data = $urandom;
    end
    wait_req(ok);
    if (!ok) fail("final_wait");
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("final_pc", imem_addr, mpc);
    mon_on = 0;
    ovr = 1;
    imem_ack = 1'b1;
    imem_data = $urandom;
    @(negedge clock);
    imem_ack = 1'b0;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      #2;
      if (executing && cw_out[3]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("exec_wait");
    chk("ovr_k", k_out, 64'hFFFF);
    chk("ovr_ramw", {63'd0, cw_out[7]}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc, RPC);
    chk("mid_rst_cw", {33'd0, cw_out}, 64'd0);
    chk("mid_rst_k", k_out, 64'd0);
    chk("mid_rst_exec", {63'd0, executing}, 64'd0);
    chk("mid_rst_state", {62'd0, state}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Consumer side of the per-instruction control-word protocol.
- Fetches a 32-bit instruction and presents it with the 2-bit micro-state to the instruction decoders (BR, etc.).
- Registers the 31-bit control word, nextState and K they return, and unpacks the word into datapath strobes.
- Owns the 64-bit program counter and applies the Psel/PCsel PC-update rules.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- PC_STEP, 64'd4, increment applied for Psel=01.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  32  fetched instruction.
- instruction  out  32  instruction register, to decoders.
- state  out  2  current micro-state, to decoders.
- cw_in  in  31  control word {Psel[30:29],DA[28:24],SA[23:19],SB[18:14],Fsel[13:9],regW[8],ramW[7],EN_MEM[6],EN_ALU[5],EN_B[4],EN_PC[3],Bsel[2],PCsel[1],SL[0]}.
- next_state_in  in  2  decoder nextState.
- k_in  in  64  decoder constant K.
- a_bus  in  64  register-file A output, the PC operand when PCsel=1.
- dp_stall  in  1  datapath busy (e.g. data memory); freezes EXEC.
- pc  out  64  program counter.
- cw_out  out  31  registered control word, write bits gated (see below).
- k_out  out  64  registered K.
- executing  out  1  high while in EXEC.

Behaviour:
- State machine FETCH, EXEC. Reset enters FETCH.
- Reset values:
  - pc=RESET_PC.
  - instruction=0, state=0, cw_out=0, k_out=0.
  - imem_req=0 for the first cycle after reset deasserts, then 1.
  - executing=0.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack: instruction<=imem_data, state<=0, go to EXEC.
  - Without imem_ack: hold FETCH, any number of cycles.
- EXEC, cw register:
  - cw_out/k_out are registered copies of cw_in/k_in, captured on the clock edge that enters EXEC and on every non-stalled EXEC edge. The decoders are combinational, so this gives one-cycle latency from instruction/state to cw_out.
  - The first EXEC cycle is a capture cycle: strobes are forced to 0 (regW, ramW, EN_*). Next edge goes to the execute phase.
- EXEC, execute phase:
  - cw_out carries the live strobes.
  - If dp_stall=1: all registers hold, and the strobes stay asserted.
  - If dp_stall=0, at the edge:
    - pc is updated from registered Psel:
      - 00: hold.
      - 01: pc+PC_STEP.
      - 10: pc + operand.
      - 11: operand.
      - operand = a_bus if PCsel=1, else k_out.
    - If the registered nextState is non-zero: state<=nextState, re-enter the capture cycle.
    - Otherwise: state<=0 and go to FETCH.
- Arithmetic: 64-bit modulo 2^64. Wrap-around is silent, with no fault.
- regW/ramW are asserted on cw_out only in execute-phase cycles. They are never asserted in FETCH or capture cycles.
- imem_ack while in EXEC is ignored.
- Reset mid-operation (any state, including a stall or a pending ack): all registers return to their reset values immediately. No partial PC update.
- A decoder returning nextState equal to the current state loops. This is legal, with no watchdog.

Decomposition:
- Shared package cw_pkg holds:
  - Field bit-position localparams for the 31-bit control word.
  - Psel encodings PSEL_HOLD=00, PSEL_INC=01, PSEL_REL=10, PSEL_ABS=11.
  - FSM state encodings.
- One natural sub-module: pc_unit (PC register, Psel/PCsel mux, adder). The FSM and the cw/IR registers stay in the top.

Test Plan:
- Reset with RESET_PC=64'h100 → pc=0x100, imem_req=0 then 1; imem_addr=0x100.
- Fetch with imem_ack delayed 3 cycles, imem_data=32'h8B020020 → instruction latched on the ack edge; state=0; executing=1 next cycle.
- BR-style cw (Psel=10, PCsel=1, regW=0) with a_bus=0x40 and pc=0x100 → after the execute edge pc=0x140, back in FETCH, regW never high.
- Two-state instruction: next_state_in=01 then 00, Psel=00 then 01 → state sequence 0,1 then FETCH; pc+4 applied only at the second execute.
- dp_stall held 2 cycles during execute with ramW=1 → ramW high for 3 cycles, pc and state frozen, single PC update after release.
- Async reset asserted mid-execute with Psel=11, k_out=0xFFFF → no update, pc=RESET_PC at once, cw_out=0.
